shifter_seq_right: RTL and testbench
====================================

Name: shifter_seq_right

Overview:
- Iterative, multi-cycle right-shift/rotate unit for the ALU shift path. It is the right-direction counterpart of the combinational left shifter.
- Resolves one shift-amount bit per cycle, MSB stage first (2^(SHAMT_W-1), ..., 4, 2, 1). This trades latency for area and timing.
- Operands are accepted with a start/done handshake from the execute-stage controller. The result is held until the next accepted start.

Parameters:
- WIDTH, 16, data width in bits; must equal 2^SHAMT_W.
- SHAMT_W, 4, shift-amount width in bits; equals the number of shift stages.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on clk when the block is in IDLE or DONE.
- mode  input  2  operation: 00 = SRL (logical), 01 = SRA (arithmetic), 10 = ROR (rotate right), 11 = illegal.
- shift_in  input  WIDTH  data to be shifted; latched on an accepted start.
- shift_val  input  SHAMT_W  shift amount; latched on an accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; shift_out and err are valid during it.
- shift_out  output  WIDTH  result register.
- err  output  1  set with done when mode was 11.

Behaviour:
- Reset: the synchronous rst forces state=IDLE and clears every output: busy=0, done=0, shift_out=0, err=0. The internal data, amount, mode and stage registers are also cleared. Reset wins over start on the same edge, including when asserted mid-operation: the partial result is discarded and no done is produced.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 latches shift_in into the data register, and shift_val and mode into their registers.
  - It sets stage=SHAMT_W-1 and moves to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT, each cycle:
  - If the latched amount bit[stage] is 1, the data register becomes the data shifted right by 2^stage.
  - SRL fills the vacated MSBs with 0. SRA fills them with the original bit[WIDTH-1] latched at start. ROR feeds the bits shifted out at the LSB end back in at the MSB end.
  - If the amount bit is 0, the data is unchanged.
  - stage decrements each cycle. After the stage-0 cycle the data register is copied to shift_out and the block moves to DONE.
  - start is ignored while in SHIFT.
- Illegal mode (11): the block still occupies the SHIFT cycles, but the data is never modified. shift_out therefore equals the latched shift_in, and err=1 alongside done.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted: operands are latched and the block goes straight to SHIFT, giving back-to-back operation with no IDLE gap. Otherwise it goes to IDLE.
  - err is updated only when entering DONE, and holds its value until the next DONE.
- Latency: the start edge is cycle 0. busy is high in cycles 1..SHAMT_W and done is high in cycle SHAMT_W+1, which is cycle 5 at the defaults. Throughput is one result per SHAMT_W+1 cycles.
- Stability:
  - shift_out changes only when entering DONE or on reset, and holds its value in IDLE.
  - shift_in, shift_val and mode may change freely after the start edge.
- Boundaries:
  - An amount of 0 still takes the full latency and returns the input unchanged.
  - The maximum amount (WIDTH-1) with SRA yields all-sign bits.
  - ROR by any amount preserves the popcount of the data.

Optional Feature:
- Macro: SHIFT_SEQ_ZERO_BYPASS_EN.
- Defined: an accepted start with shift_val==0, or with mode==11, skips SHIFT and moves directly to DONE. done is then asserted in cycle 1 with shift_out=shift_in, and err set as for an illegal mode. busy never rises for these operations.
- Undefined: every operation takes the full SHAMT_W+1-cycle latency.

Test Plan:
- SRL: shift_in=0x8000, shift_val=4, mode=00 -> shift_out=0x0800, err=0; busy high in cycles 1..4; done pulses in cycle 5 only.
- SRA and ROR:
  - mode=01, shift_in=0x8000, shift_val=4 -> 0xF800.
  - mode=01, shift_in=0x8001, shift_val=15 -> 0xFFFF.
  - mode=10, shift_in=0x1234, shift_val=4 -> 0x4123.
- Back-to-back: assert start in the done cycle of the 0x1234 ROR-by-4 operation, with mode=00, shift_in=0x00F0, shift_val=8 -> the second done arrives 5 cycles later with shift_out=0x0000. There is no IDLE cycle between the two operations.
- Illegal mode: mode=11, shift_in=0xA5A5, shift_val=3 -> done in cycle 5, shift_out=0xA5A5, err=1. A following legal operation clears err.
- Reset mid-op: start an SRL, then assert rst in cycle 2 -> next cycle busy=0, done=0, shift_out=0, err=0. No done pulse occurs afterwards, and a new start behaves normally.
- Zero amount: shift_val=0, shift_in=0x5A5A -> shift_out=0x5A5A. done arrives in cycle 5 without SHIFT_SEQ_ZERO_BYPASS_EN, or in cycle 1 with it (busy stays 0).

Source files
------------

// File: rtl/shifter_seq_right.sv
// Iterative right shifter/rotator (SRL/SRA/ROR) that resolves one shift-amount bit per cycle, MSB stage first.
// Optional: define SHIFT_SEQ_ZERO_BYPASS_EN so a zero amount or an illegal mode goes straight to DONE.
module shifter_seq_right #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   shift_in,
  input  logic [SHAMT_W-1:0] shift_val,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   shift_out,
  output logic               err
);

  localparam int STAGE_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {MODE_SRL, MODE_SRA, MODE_ROR, MODE_ILL} mode_t;

  state_t                          state_q, state_d;
  mode_t                           mode_q;
  logic [WIDTH-1:0]                data_q;
  logic [SHAMT_W-1:0]              amt_q;
  logic [STAGE_W-1:0]              stage_q;
  logic [SHAMT_W-1:0][WIDTH-1:0]   stage_res;
  logic [WIDTH-1:0]                step_data;
  logic                            accept;
  logic                            bypass;

  // Each stage shifts by a constant 2^g, so every candidate result is plain wiring.
  // SRA fills from data_q's MSB: an arithmetic shift never changes the MSB, so it
  // still holds the sign bit latched at start.
  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    localparam int SH = 1 << g;
    assign stage_res[g] =
        (mode_q == MODE_SRL) ? {{SH{1'b0}},          data_q[WIDTH-1:SH]} :
        (mode_q == MODE_SRA) ? {{SH{data_q[WIDTH-1]}}, data_q[WIDTH-1:SH]} :
        (mode_q == MODE_ROR) ? {data_q[SH-1:0],      data_q[WIDTH-1:SH]} :
                               data_q;
  end

  assign step_data = amt_q[stage_q] ? stage_res[stage_q] : data_q;
  assign accept    = start && (state_q != SHIFT);

`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
  assign bypass = (shift_val == '0) || (mode == 2'b11);
`else
  assign bypass = 1'b0;
`endif

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = bypass ? DONE : SHIFT;
        else        state_d = IDLE;
      end
      SHIFT:   if (stage_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_SRL;
      data_q    <= '0;
      amt_q     <= '0;
      stage_q   <= '0;
      shift_out <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q  <= shift_in;
        amt_q   <= shift_val;
        mode_q  <= mode_t'(mode);
        stage_q <= STAGE_W'(SHAMT_W - 1);
        if (bypass) begin
          shift_out <= shift_in;
          err       <= (mode == 2'b11);
        end
      end else if (state_q == SHIFT) begin
        data_q  <= step_data;
        stage_q <= stage_q - 1'b1;
        if (stage_q == '0) begin
          shift_out <= step_data;
          err       <= (mode_q == MODE_ILL);
        end
      end
    end
  end

endmodule

// File: tb/tb_shifter_seq_right.sv
// Self-checking bench for shifter_seq_right: directed steps with a scoreboard of expected results.
// Honours SHIFT_SEQ_ZERO_BYPASS_EN for the expected latency of zero-amount and illegal-mode operations.
module tb_shifter_seq_right;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] shift_in;
  logic [3:0]  shift_val;
  logic        busy;
  logic        done;
  logic [15:0] shift_out;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        err;
    logic [1:0]  mode;
    int          lat;
  } exp_t;

  exp_t sb[$];

  shifter_seq_right #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .shift_in  (shift_in),
    .shift_val (shift_val),
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
    logic [31:0] dd;
    case (m)
      2'b00:   model = d >> a;
      2'b01:   model = 16'($signed(d) >>> a);
      2'b10:   begin dd = {d, d} >> a; model = dd[15:0]; end
      default: model = d;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] a, input logic [1:0] m);
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
    latency = (a == 4'd0 || m == 2'b11) ? 1 : 5;
`else
    latency = 5 + 0 * int'(a) + 0 * int'(m);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted start; returns #1 into cycle 1 with operands scrambled.
  task automatic launch(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
    exp_t e;
    e.din  = d;
    e.dout = model(d, a, m);
    e.err  = (m == 2'b11);
    e.mode = m;
    e.lat  = latency(a, m);
    sb.push_back(e);
    shift_in  = d;
    shift_val = a;
    mode      = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    shift_in  = 16'($urandom);
    shift_val = 4'($urandom);
    mode      = 2'($urandom);
  endtask

  // Waits (bounded) for done, checking busy per cycle; returns #1 into the done cycle.
  task automatic wait_done(input string tag);
    exp_t e;
    int   c;
    logic seen;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e    = sb.pop_front();
    seen = 1'b0;
    for (c = 1; c <= 20; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check({tag, "_busy"}, 32'(busy), 32'(c < e.lat));
      tick();
    end
    check({tag, "_latency"}, c, e.lat);
    if (seen) begin
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_data"}, 32'(shift_out), 32'(e.dout));
      check({tag, "_err"}, 32'(err), 32'(e.err));
      if (e.mode == 2'b10)
        check({tag, "_popcount"}, $countones(shift_out), $countones(e.din));
    end
  endtask

  initial begin
    logic seen_done;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 2'b00;
    shift_in  = 16'h0;
    shift_val = 4'h0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out",  32'(shift_out), 32'd0);
    check("rst_err",  32'(err), 32'd0);
    rst = 1'b0;
    tick();

    launch(16'h8000, 4'd4, 2'b00);
    wait_done("srl_8000_4");
    tick();
    check("srl_done_one_cycle", 32'(done), 32'd0);

    launch(16'h8000, 4'd4, 2'b01);
    wait_done("sra_8000_4");
    tick();
    launch(16'h8001, 4'd15, 2'b01);
    wait_done("sra_8001_15");
    tick();

    // Second start issued in the done cycle of the first.
    launch(16'h1234, 4'd4, 2'b10);
    wait_done("ror_1234_4");
    launch(16'h00F0, 4'd8, 2'b00);
    wait_done("b2b_srl_00f0_8");
    tick();

    launch(16'hA5A5, 4'd3, 2'b11);
    wait_done("illegal_a5a5");
    tick();
    launch(16'hF00F, 4'd1, 2'b00);
    wait_done("legal_after_illegal");
    tick();
    tick();
    tick();
    check("hold_out_idle", 32'(shift_out), 32'h7807);
    check("hold_done_idle", 32'(done), 32'd0);

    // Reset in cycle 2 of an SRL discards the operation.
    launch(16'hFFFF, 4'd2, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out",  32'(shift_out), 32'd0);
    check("midrst_err",  32'(err), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);

    launch(16'h8001, 4'd1, 2'b10);
    wait_done("after_rst_ror");
    tick();

    launch(16'h5A5A, 4'd0, 2'b00);
    wait_done("zero_amount");
    tick();

    for (int i = 0; i < 6; i++) begin
      launch(16'($urandom), 4'($urandom), 2'($urandom_range(0, 2)));
      wait_done($sformatf("rand_%0d", i));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
